// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the MEM pipeline stage: datapath widths, memory
//   access encodings, exception codes, instruction opcodes, the active level
//   of the GPR write strobe and the MEM-stage FSM state type.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int PC_WIDTH           = 32;
    localparam int WORD_WIDTH         = 32;
    localparam int GPR_ADDR_WIDTH     = 5;
    localparam int DATA_WIDTH_MEM_OP  = 4;
    localparam int DATA_WIDTH_ISA_EXP = 4;

    // GPR write strobe is active low: WRITE is the level that performs a write.
    localparam logic WRITE = 1'b0;

    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_NOP = 4'd0;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LB  = 4'd1;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LH  = 4'd2;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LW  = 4'd3;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LBU = 4'd4;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LHU = 4'd5;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SB  = 4'd6;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SH  = 4'd7;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SW  = 4'd8;

    localparam logic [DATA_WIDTH_ISA_EXP-1:0] ISA_EXP_NONE       = 4'd0;
    localparam logic [DATA_WIDTH_ISA_EXP-1:0] ISA_EXP_MISALIGNED = 4'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Halfword accesses need addr[0] clear, word accesses need addr[1:0] clear.
    function automatic logic is_misaligned(input logic [DATA_WIDTH_MEM_OP-1:0] op,
                                           input logic [1:0]                   addr);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return addr[0];
            MEM_OP_LW, MEM_OP_SW:             return addr != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Combinational load-data alignment: picks the byte or halfword lane out of
//   the bus read word and sign- or zero-extends it to a full word.
//   Ports:
//     mem_op    in   access type (LB/LH/LW/LBU/LHU; anything else passes rdata)
//     addr      in   low two bits of the byte address (lane select)
//     rdata     in   raw word returned by the data bus
//     load_data out  aligned, extended value for the register file
// -----------------------------------------------------------------------------
module load_align
    import mem_ctrl_pkg::*;
(
    input  logic [DATA_WIDTH_MEM_OP-1:0] mem_op,
    input  logic [1:0]                   addr,
    input  logic [WORD_WIDTH-1:0]        rdata,
    output logic [WORD_WIDTH-1:0]        load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        case (mem_op)
            MEM_OP_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
            MEM_OP_LBU: load_data = {24'b0, byte_lane};
            MEM_OP_LH:  load_data = {{16{half_lane[15]}}, half_lane};
            MEM_OP_LHU: load_data = {16'b0, half_lane};
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   MEM pipeline stage: issues data-bus accesses, stalls the pipeline while a
//   transaction is outstanding, aligns load data and registers the results
//   towards WB.
//
//   Bus handshake: bus_req is raised with address/data/strobes valid and held,
//   together with those fields, until a cycle in which bus_ack is high; that
//   cycle completes the transfer (bus_rdata valid in the same cycle). A
//   transfer that has been requested is always carried to its ack, even if the
//   instruction is flushed meanwhile; only reset abandons it.
//
//   Ports:
//     clk, rst, cpu_en        clock, sync active-high reset, global hold
//     mem_flush               kill the instruction in this stage
//     ex_*                    EX/MEM pipeline register contents
//     bus_req/we/addr/wdata/byteena  data-bus request (outputs)
//     bus_rdata, bus_ack      data-bus response (inputs)
//     mem_stall_req           combinational stall request to cpu_ctrl
//     mem_*                   registered MEM/WB values
//     dbg_state_o, dbg_kill_o FSM state and pending-kill flag for observation
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_en,
    input  logic                          mem_flush,
    input  logic [PC_WIDTH-1:0]           ex_pc,
    input  logic [WORD_WIDTH-1:0]         ex_insn,
    input  logic                          ex_en,
    input  logic                          ex_gpr_we_,
    input  logic [GPR_ADDR_WIDTH-1:0]     ex_dst_addr,
    input  logic [WORD_WIDTH-1:0]         ex_alu_out,
    input  logic [WORD_WIDTH-1:0]         ex_csr_to_gpr_data,
    input  logic [DATA_WIDTH_MEM_OP-1:0]  ex_mem_op,
    input  logic                          ex_memory_we_en,
    input  logic                          ex_memory_rd_en,
    input  logic [WORD_WIDTH-1:0]         ex_store_data,
    input  logic [3:0]                    ex_store_byteena,
    input  logic [DATA_WIDTH_ISA_EXP-1:0] ex_exp_code,
    output logic                          bus_req,
    output logic                          bus_we,
    output logic [WORD_WIDTH-1:0]         bus_addr,
    output logic [WORD_WIDTH-1:0]         bus_wdata,
    output logic [3:0]                    bus_byteena,
    input  logic [WORD_WIDTH-1:0]         bus_rdata,
    input  logic                          bus_ack,
    output logic                          mem_stall_req,
    output logic [PC_WIDTH-1:0]           mem_pc,
    output logic [WORD_WIDTH-1:0]         mem_insn,
    output logic                          mem_en,
    output logic                          mem_gpr_we_,
    output logic [GPR_ADDR_WIDTH-1:0]     mem_dst_addr,
    output logic [WORD_WIDTH-1:0]         mem_gpr_data,
    output logic [DATA_WIDTH_ISA_EXP-1:0] mem_exp_code,
    output logic                          dbg_state_o,
    output logic                          dbg_kill_o
);

    mem_state_e state_q, state_d;
    logic       kill_q, kill_d;

    logic [PC_WIDTH-1:0]           mem_pc_q,       mem_pc_d;
    logic [WORD_WIDTH-1:0]         mem_insn_q,     mem_insn_d;
    logic                          mem_en_q,       mem_en_d;
    logic                          mem_gpr_we_q,   mem_gpr_we_d;
    logic [GPR_ADDR_WIDTH-1:0]     mem_dst_addr_q, mem_dst_addr_d;
    logic [WORD_WIDTH-1:0]         mem_gpr_data_q, mem_gpr_data_d;
    logic [DATA_WIDTH_ISA_EXP-1:0] mem_exp_code_q, mem_exp_code_d;

    logic                  misalign;
    logic                  access;
    logic                  load_acc;
    logic                  is_system;
    logic                  bubble;
    logic [WORD_WIDTH-1:0] load_data;
    logic [WORD_WIDTH-1:0] gpr_data;

    assign misalign  = is_misaligned(ex_mem_op, ex_alu_out[1:0]);
    assign access    = ex_en & (ex_memory_rd_en | ex_memory_we_en) & ~misalign;
    assign load_acc  = access & ex_memory_rd_en;
    assign is_system = (ex_insn[6:0] == OP_SYSTEM);

    load_align u_load_align (
        .mem_op    (ex_mem_op),
        .addr      (ex_alu_out[1:0]),
        .rdata     (bus_rdata),
        .load_data (load_data)
    );

    assign gpr_data = load_acc  ? load_data          :
                      is_system ? ex_csr_to_gpr_data :
                                  ex_alu_out;

    // FSM next state and the combinational bus/stall outputs.
    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        bus_req       = 1'b0;
        mem_stall_req = 1'b0;
        bubble        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus_req = access & ~mem_flush;
                if (bus_req && !bus_ack) begin
                    mem_stall_req = 1'b1;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                bus_req = 1'b1;
                // With cpu_en low nothing can be captured, so an ack in that
                // cycle is not treated as completion.
                if (bus_ack && cpu_en) begin
                    state_d = ST_IDLE;
                    kill_d  = 1'b0;
                    bubble  = kill_q;
                end else begin
                    mem_stall_req = 1'b1;
                    if (mem_flush) begin
                        kill_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        bubble = bubble | mem_flush | mem_stall_req;
    end

    always_comb begin
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_byteena = 4'b0000;
        if (bus_req) begin
            bus_we      = ex_memory_we_en;
            bus_addr    = {ex_alu_out[WORD_WIDTH-1:2], 2'b00};
            bus_wdata   = ex_store_data;
            bus_byteena = ex_store_byteena;
        end
    end

    // Next values of the MEM/WB register: capture, or a non-writing bubble.
    always_comb begin
        mem_pc_d       = ex_pc;
        mem_insn_d     = ex_insn;
        mem_en_d       = ex_en;
        mem_gpr_we_d   = ex_gpr_we_;
        mem_dst_addr_d = ex_dst_addr;
        mem_gpr_data_d = gpr_data;
        mem_exp_code_d = misalign ? ISA_EXP_MISALIGNED : ex_exp_code;
        if (bubble) begin
            mem_pc_d       = '0;
            mem_insn_d     = '0;
            mem_en_d       = 1'b0;
            mem_gpr_we_d   = ~WRITE;
            mem_dst_addr_d = '0;
            mem_gpr_data_d = '0;
            mem_exp_code_d = ISA_EXP_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            kill_q         <= 1'b0;
            mem_pc_q       <= '0;
            mem_insn_q     <= '0;
            mem_en_q       <= 1'b0;
            mem_gpr_we_q   <= ~WRITE;
            mem_dst_addr_q <= '0;
            mem_gpr_data_q <= '0;
            mem_exp_code_q <= ISA_EXP_NONE;
        end else if (cpu_en) begin
            state_q        <= state_d;
            kill_q         <= kill_d;
            mem_pc_q       <= mem_pc_d;
            mem_insn_q     <= mem_insn_d;
            mem_en_q       <= mem_en_d;
            mem_gpr_we_q   <= mem_gpr_we_d;
            mem_dst_addr_q <= mem_dst_addr_d;
            mem_gpr_data_q <= mem_gpr_data_d;
            mem_exp_code_q <= mem_exp_code_d;
        end
    end

    assign mem_pc       = mem_pc_q;
    assign mem_insn     = mem_insn_q;
    assign mem_en       = mem_en_q;
    assign mem_gpr_we_  = mem_gpr_we_q;
    assign mem_dst_addr = mem_dst_addr_q;
    assign mem_gpr_data = mem_gpr_data_q;
    assign mem_exp_code = mem_exp_code_q;
    assign dbg_state_o  = state_q;
    assign dbg_kill_o   = kill_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//   Directed bench for mem_ctrl. Inputs change 1 time unit after the rising
//   edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic        mem_flush;
    logic [31:0] ex_pc;
    logic [31:0] ex_insn;
    logic        ex_en;
    logic        ex_gpr_we_;
    logic [4:0]  ex_dst_addr;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_csr_to_gpr_data;
    logic [3:0]  ex_mem_op;
    logic        ex_memory_we_en;
    logic        ex_memory_rd_en;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_store_byteena;
    logic [3:0]  ex_exp_code;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteena;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        mem_stall_req;
    logic [31:0] mem_pc;
    logic [31:0] mem_insn;
    logic        mem_en;
    logic        mem_gpr_we_;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_gpr_data;
    logic [3:0]  mem_exp_code;
    logic        dbg_state_o;
    logic        dbg_kill_o;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_en             (cpu_en),
        .mem_flush          (mem_flush),
        .ex_pc              (ex_pc),
        .ex_insn            (ex_insn),
        .ex_en              (ex_en),
        .ex_gpr_we_         (ex_gpr_we_),
        .ex_dst_addr        (ex_dst_addr),
        .ex_alu_out         (ex_alu_out),
        .ex_csr_to_gpr_data (ex_csr_to_gpr_data),
        .ex_mem_op          (ex_mem_op),
        .ex_memory_we_en    (ex_memory_we_en),
        .ex_memory_rd_en    (ex_memory_rd_en),
        .ex_store_data      (ex_store_data),
        .ex_store_byteena   (ex_store_byteena),
        .ex_exp_code        (ex_exp_code),
        .bus_req            (bus_req),
        .bus_we             (bus_we),
        .bus_addr           (bus_addr),
        .bus_wdata          (bus_wdata),
        .bus_byteena        (bus_byteena),
        .bus_rdata          (bus_rdata),
        .bus_ack            (bus_ack),
        .mem_stall_req      (mem_stall_req),
        .mem_pc             (mem_pc),
        .mem_insn           (mem_insn),
        .mem_en             (mem_en),
        .mem_gpr_we_        (mem_gpr_we_),
        .mem_dst_addr       (mem_dst_addr),
        .mem_gpr_data       (mem_gpr_data),
        .mem_exp_code       (mem_exp_code),
        .dbg_state_o        (dbg_state_o),
        .dbg_kill_o         (dbg_kill_o)
    );

    // Completed bus writes, observed at the sampling edge.
    always @(negedge clk) begin
        if (bus_req && bus_ack && bus_we) wr_cnt = wr_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drv_nop();
        ex_pc              = 32'h0;
        ex_insn            = 32'h0;
        ex_en              = 1'b0;
        ex_gpr_we_         = 1'b1;
        ex_dst_addr        = 5'd0;
        ex_alu_out         = 32'h0;
        ex_csr_to_gpr_data = 32'h0;
        ex_mem_op          = MEM_OP_NOP;
        ex_memory_we_en    = 1'b0;
        ex_memory_rd_en    = 1'b0;
        ex_store_data      = 32'h0;
        ex_store_byteena   = 4'b0000;
        ex_exp_code        = 4'd0;
    endtask

    task automatic drv_load(input logic [3:0] op, input logic [31:0] addr);
        drv_nop();
        ex_insn         = {25'h0, OP_LOAD};
        ex_en           = 1'b1;
        ex_gpr_we_      = 1'b0;
        ex_dst_addr     = 5'd7;
        ex_alu_out      = addr;
        ex_mem_op       = op;
        ex_memory_rd_en = 1'b1;
    endtask

    task automatic drv_store(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
        drv_nop();
        ex_insn          = 32'h0000_0023;
        ex_en            = 1'b1;
        ex_alu_out       = addr;
        ex_mem_op        = op;
        ex_memory_we_en  = 1'b1;
        ex_store_data    = data;
        ex_store_byteena = be;
    endtask

    task automatic drv_alu(input logic [31:0] insn, input logic [31:0] alu,
                           input logic [31:0] csr, input logic [3:0] exp);
        drv_nop();
        ex_insn            = insn;
        ex_en              = 1'b1;
        ex_gpr_we_         = 1'b0;
        ex_dst_addr        = 5'd3;
        ex_alu_out         = alu;
        ex_csr_to_gpr_data = csr;
        ex_exp_code        = exp;
    endtask

    // Zero-wait load: starts and ends on a falling edge.
    task automatic fast_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
        tick();
        drv_load(op, addr);
        bus_rdata = rdata;
        bus_ack   = 1'b1;
        sample();
        check_eq({tag, "_stall"}, mem_stall_req, 0);
        tick();
        drv_nop();
        bus_ack = 1'b0;
        sample();
        check_eq({tag, "_data"}, mem_gpr_data, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wr_start;
        rst       = 1'b1;
        cpu_en    = 1'b1;
        mem_flush = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        drv_nop();

        // Reset values
        tick();
        tick();
        sample();
        check_eq("rst_bus_req", bus_req, 0);
        check_eq("rst_stall", mem_stall_req, 0);
        check_eq("rst_state", dbg_state_o, 0);
        check_eq("rst_kill", dbg_kill_o, 0);
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_gpr_we_", mem_gpr_we_, 1);
        check_eq("rst_gpr_data", mem_gpr_data, 0);
        check_eq("rst_exp", mem_exp_code, 0);
        rst = 1'b0;

        // LW 0x100, ack in the same cycle
        tick();
        drv_load(MEM_OP_LW, 32'h100);
        ex_pc       = 32'h1000;
        ex_dst_addr = 5'd5;
        bus_rdata   = 32'hDEADBEEF;
        bus_ack     = 1'b1;
        sample();
        check_eq("lw_bus_req", bus_req, 1);
        check_eq("lw_bus_addr", bus_addr, 32'h100);
        check_eq("lw_bus_we", bus_we, 0);
        check_eq("lw_stall", mem_stall_req, 0);
        tick();
        drv_nop();
        bus_ack = 1'b0;
        sample();
        check_eq("lw_data", mem_gpr_data, 32'hDEADBEEF);
        check_eq("lw_mem_en", mem_en, 1);
        check_eq("lw_mem_pc", mem_pc, 32'h1000);
        check_eq("lw_dst", mem_dst_addr, 5);
        check_eq("lw_gpr_we_", mem_gpr_we_, 0);
        check_eq("idle_bus_req", bus_req, 0);

        // LB 0x103, ack after 3 wait cycles
        tick();
        drv_load(MEM_OP_LB, 32'h103);
        bus_rdata = 32'h80FF_FF7F;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_eq("lb_stall", mem_stall_req, 1);
            check_eq("lb_bus_addr", bus_addr, 32'h100);
            if (i > 0) check_eq("lb_bubble_en", mem_en, 0);
            tick();
        end
        bus_ack = 1'b1;
        sample();
        check_eq("lb_ack_stall", mem_stall_req, 0);
        tick();
        drv_nop();
        bus_ack = 1'b0;
        sample();
        check_eq("lb_data", mem_gpr_data, 32'hFFFF_FF80);
        check_eq("lb_mem_en", mem_en, 1);
        check_eq("lb_state", dbg_state_o, 0);

        // Lane selection / extension
        fast_load("lhu_102", MEM_OP_LHU, 32'h102, 32'hBEEF_1234, 32'h0000_BEEF);
        fast_load("lh_102",  MEM_OP_LH,  32'h102, 32'hBEEF_1234, 32'hFFFF_BEEF);
        fast_load("lh_100",  MEM_OP_LH,  32'h100, 32'h1234_8765, 32'hFFFF_8765);
        fast_load("lbu_101", MEM_OP_LBU, 32'h101, 32'h80FF_FF7F, 32'h0000_00FF);
        fast_load("lb_100",  MEM_OP_LB,  32'h100, 32'h80FF_FF7F, 32'h0000_007F);

        // Non-memory: ALU result, then CSR data for a SYSTEM opcode
        tick();
        drv_alu(32'h0000_0033, 32'h1234, 32'hCAFE, 4'd2);
        sample();
        check_eq("alu_bus_req", bus_req, 0);
        tick();
        drv_alu(32'h3000_2073, 32'h5678, 32'hCAFE, 4'd0);
        sample();
        check_eq("alu_data", mem_gpr_data, 32'h1234);
        check_eq("alu_exp", mem_exp_code, 2);
        tick();
        drv_nop();
        sample();
        check_eq("csr_data", mem_gpr_data, 32'hCAFE);

        // Misaligned SW 0x202
        tick();
        drv_store(MEM_OP_SW, 32'h202, 32'h1111_2222, 4'hF);
        sample();
        check_eq("sw_mis_bus_req", bus_req, 0);
        check_eq("sw_mis_stall", mem_stall_req, 0);
        tick();
        drv_nop();
        sample();
        check_eq("sw_mis_exp", mem_exp_code, ISA_EXP_MISALIGNED);

        // SB with flush while waiting: write still completes, result killed
        tick();
        wr_start = wr_cnt;
        drv_store(MEM_OP_SB, 32'h302, 32'h00AB_0000, 4'b0100);
        sample();
        check_eq("sb_bus_req", bus_req, 1);
        check_eq("sb_bus_we", bus_we, 1);
        check_eq("sb_bus_addr", bus_addr, 32'h300);
        check_eq("sb_bus_wdata", bus_wdata, 32'h00AB_0000);
        check_eq("sb_bus_be", bus_byteena, 4'b0100);
        tick();
        mem_flush = 1'b1;
        sample();
        check_eq("sb_flush_state", dbg_state_o, 1);
        check_eq("sb_flush_bus_req", bus_req, 1);
        tick();
        mem_flush = 1'b0;
        sample();
        check_eq("sb_kill", dbg_kill_o, 1);
        check_eq("sb_wait_stall", mem_stall_req, 1);
        tick();
        bus_ack = 1'b1;
        sample();
        check_eq("sb_ack_stall", mem_stall_req, 0);
        tick();
        drv_nop();
        bus_ack = 1'b0;
        sample();
        check_eq("sb_mem_en", mem_en, 0);
        check_eq("sb_gpr_we_", mem_gpr_we_, 1);
        check_eq("sb_kill_clr", dbg_kill_o, 0);
        check_eq("sb_state", dbg_state_o, 0);
        check_eq("sb_writes", wr_cnt - wr_start, 1);

        // cpu_en low in WAIT: ack ignored, state held
        tick();
        drv_load(MEM_OP_LW, 32'h400);
        sample();
        check_eq("hold_stall0", mem_stall_req, 1);
        tick();
        cpu_en    = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_2222;
        sample();
        check_eq("hold_stall1", mem_stall_req, 1);
        check_eq("hold_bus_req", bus_req, 1);
        tick();
        cpu_en  = 1'b1;
        bus_ack = 1'b0;
        sample();
        check_eq("hold_state", dbg_state_o, 1);
        check_eq("hold_stall2", mem_stall_req, 1);
        tick();
        bus_ack   = 1'b1;
        bus_rdata = 32'h3333_4444;
        sample();
        check_eq("hold_ack_stall", mem_stall_req, 0);
        tick();
        drv_nop();
        bus_ack = 1'b0;
        sample();
        check_eq("hold_data", mem_gpr_data, 32'h3333_4444);

        // Reset during WAIT, late ack ignored
        tick();
        drv_load(MEM_OP_LW, 32'h500);
        bus_rdata = 32'h5555_6666;
        sample();
        check_eq("rw_stall", mem_stall_req, 1);
        tick();
        rst = 1'b1;
        sample();
        tick();
        rst = 1'b0;
        drv_nop();
        bus_ack = 1'b1;
        sample();
        check_eq("rw_bus_req", bus_req, 0);
        check_eq("rw_state", dbg_state_o, 0);
        check_eq("rw_stall", mem_stall_req, 0);
        check_eq("rw_mem_en", mem_en, 0);
        check_eq("rw_gpr_we_", mem_gpr_we_, 1);
        check_eq("rw_gpr_data", mem_gpr_data, 0);
        tick();
        bus_ack = 1'b0;
        sample();
        check_eq("rw_late_en", mem_en, 0);
        check_eq("rw_late_we_", mem_gpr_we_, 1);
        check_eq("rw_late_data", mem_gpr_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
